line_pingpong_writer: RTL
=========================

Name: line_pingpong_writer

Overview:
- Upstream stage of the ping-pong line memory.
- Packs a serial stream of binarised pixels (1 bit each) into DATA_WIDTH-bit line words.
- Commits each completed line alternately into bank A or bank B.
- Drives the bank-select line consumed by the downstream output selector, which passes A when select=1 and B when select=0.
- Uses a ready/ack handshake toward the line consumer and drops lines on overflow.

Parameters:
- DATA_WIDTH, 640: pixels per line; also the width of each bank word.
- CNT_W, $clog2(DATA_WIDTH+1): width of the pixel counter (derived; not overridden).
- DROP_W, 8: width of the saturating dropped-line counter.

Ports:
- iCLK  input  1  system clock; all logic on the rising edge.
- iRST  input  1  synchronous reset, active-high.
- iPIX_VALID  input  1  pixel qualifier.
- iPIX_DATA  input  1  binarised pixel.
- iLINE_START  input  1  marks the first pixel of a line; qualified by iPIX_VALID.
- iLINE_END  input  1  marks the last pixel of a short line; qualified by iPIX_VALID.
- oPIX_READY  output  1  block accepts a pixel this cycle.
- oMEMOUT_0A  output  DATA_WIDTH  bank A contents.
- oMEMOUT_0B  output  DATA_WIDTH  bank B contents.
- oMEM_SEL  output  1  1 = bank A holds the newest line, 0 = bank B.
- oLINE_RDY  output  1  newest committed line is unconsumed.
- iLINE_ACK  input  1  consumer has finished with the selected bank.
- oOVF  output  1  one-cycle pulse when a completed line is dropped.
- oDROP_CNT  output  DROP_W  saturating count of dropped lines.

Behaviour:
- Reset (iRST=1 at a clock edge): state IDLE; banks, assembly register, counter, oMEM_SEL, oLINE_RDY, oOVF, oDROP_CNT all 0; write bank = A; pending = 0.
- Accept rule: a pixel is accepted when iPIX_VALID and oPIX_READY are both 1. Otherwise it is ignored and not counted.
- oPIX_READY: 1 in IDLE and FILL, 0 in COMMIT.
- Packing: pixel k of a line lands in assembly bit k, LSB first. Unwritten bits are 0.
- State IDLE:
  - Waits for an accepted pixel with iLINE_START=1.
  - On that pixel: assembly := 0 with bit0 = pixel; count := 1; go to FILL.
  - Accepted pixels without iLINE_START are discarded.
- State FILL:
  - Each accepted pixel is written at index count; count increments.
  - Accepted pixel with iLINE_START=1: the partial line is abandoned and assembly restarts with this pixel (count := 1). No flag is raised.
  - The line completes on the accepted pixel that makes count = DATA_WIDTH, or on an accepted pixel with iLINE_END=1. The completing pixel is included; a short line is zero-padded. Go to COMMIT.
  - iLINE_START and iLINE_END on the same pixel: one-pixel line.
- State COMMIT (exactly one cycle), then IDLE:
  - If pending = 0 after this cycle's ack is applied:
    - copy assembly into the write bank;
    - oMEM_SEL := (write bank == A);
    - oLINE_RDY := 1; pending := 1;
    - write bank toggles.
  - Else:
    - bank contents, oMEM_SEL and write bank are unchanged;
    - oOVF pulses 1 for one cycle;
    - oDROP_CNT increments, saturating at all-ones.
- Latency: bank, oMEM_SEL and oLINE_RDY change at the end of the COMMIT cycle. They are visible 2 cycles after the cycle of the completing pixel.
- Handshake:
  - iLINE_ACK with oLINE_RDY=1: clears oLINE_RDY and pending at the next edge.
  - iLINE_ACK with oLINE_RDY=0: ignored.
  - Ack arriving in the COMMIT cycle: processed first, so the commit succeeds. oLINE_RDY stays 1, now referring to the new line.
- The bank the consumer reads (selected by oMEM_SEL) is never written while oLINE_RDY=1.
- iRST mid-line or mid-COMMIT: the line is lost and all state returns to reset values.

Decomposition:
- Package line_pingpong_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_FILL=2'd1, ST_COMMIT=2'd2;
  - bank IDs BANK_A=1'b1, BANK_B=1'b0, chosen to match the select polarity.
- One natural sub-module: line_assembler. It owns the counter, the assembly register, and the start/end/full detection, and outputs done plus the assembled word.
- The top level holds the FSM, the banks, the handshake and the overflow logic.

Test Plan (DATA_WIDTH=8 unless stated):
1. Reset, then a full line 1,0,1,1,0,0,1,0 with START on the first pixel → two cycles after the last pixel: oMEMOUT_0A=8'h4D, oMEM_SEL=1, oLINE_RDY=1, oOVF=0.
2. Ack the line, then send line 8'hFF → oMEMOUT_0B=8'hFF, oMEM_SEL=0, oMEMOUT_0A still 8'h4D; ack clears oLINE_RDY.
3. Short line 1,1,1 with END on the third pixel → committed word 8'h07; oPIX_READY=0 during COMMIT; a pixel offered during COMMIT is not counted.
4. Commit two lines without ack → second line dropped: oOVF high for exactly 1 cycle, oDROP_CNT=1, oMEM_SEL and the selected bank unchanged. With DROP_W=2, five drops → oDROP_CNT=3.
5. Restart and ack timing: START asserted mid-line at pixel 4 → only the new line is committed. Ack asserted in the COMMIT cycle with a line pending → commit succeeds, oLINE_RDY stays 1, oOVF=0.
6. iRST asserted on pixel 5 of a line, then a fresh line sent; plus DATA_WIDTH=640 with 640 alternating pixels → after reset all outputs 0 and the fresh line lands in bank A; the 640-pixel line commits bank A = {320{2'b10}}.

Source files
------------

// File: rtl/line_pingpong_pkg.sv
`default_nettype none
// ============================================================================
// line_pingpong_pkg : shared FSM encoding and bank IDs for the line writer
// Revision: 1.0
// ============================================================================
package line_pingpong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Bank IDs share the polarity of the downstream select line
  localparam logic BANK_A = 1'b1;
  localparam logic BANK_B = 1'b0;

endpackage
`default_nettype wire

// File: rtl/line_pingpong_writer_assembler.sv
`default_nettype none
// ============================================================================
// line_assembler : packs accepted pixels LSB-first and flags line completion
// Revision: 1.0
// ============================================================================
module line_assembler #(
  parameter int DATA_WIDTH = 640,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_accept,
  input  logic                  i_in_fill,
  input  logic                  i_pix,
  input  logic                  i_start,
  input  logic                  i_end,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_word
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  take;

  always_comb begin
    asm_d  = asm_q;
    cnt_d  = cnt_q;
    take   = i_accept && (i_start || i_in_fill);
    if (take) begin
      // A start pixel always restarts assembly, even mid-line
      if (i_start) begin
        asm_d    = '0;
        asm_d[0] = i_pix;
        cnt_d    = CNT_W'(1);
      end else begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (cnt_q == CNT_W'(i)) asm_d[i] = i_pix;
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    o_done = take && (i_end || (cnt_d == FULL_CNT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_word = asm_q;

endmodule
`default_nettype wire

// File: rtl/line_pingpong_writer.sv
`default_nettype none
// ============================================================================
// line_pingpong_writer : commits packed lines alternately into two banks
// Revision: 1.0
// ============================================================================
module line_pingpong_writer
  import line_pingpong_pkg::*;
#(
  parameter int DATA_WIDTH = 640,
  parameter int DROP_W     = 8
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iPIX_VALID,
  input  logic                  iPIX_DATA,
  input  logic                  iLINE_START,
  input  logic                  iLINE_END,
  output logic                  oPIX_READY,
  output logic [DATA_WIDTH-1:0] oMEMOUT_0A,
  output logic [DATA_WIDTH-1:0] oMEMOUT_0B,
  output logic                  oMEM_SEL,
  output logic                  oLINE_RDY,
  input  logic                  iLINE_ACK,
  output logic                  oOVF,
  output logic [DROP_W-1:0]     oDROP_CNT
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] bank_a_q, bank_a_d;
  logic [DATA_WIDTH-1:0] bank_b_q, bank_b_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  sel_q, sel_d;
  logic                  rdy_q, rdy_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic                  accept;
  logic                  done;
  logic                  pending_after;
  logic [DATA_WIDTH-1:0] asm_word;

  assign oPIX_READY = (state_q != ST_COMMIT);
  assign accept     = iPIX_VALID && oPIX_READY;

  line_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_assembler (
    .clk       (iCLK),
    .rst       (iRST),
    .i_accept  (accept),
    .i_in_fill (state_q == ST_FILL),
    .i_pix     (iPIX_DATA),
    .i_start   (iLINE_START),
    .i_end     (iLINE_END),
    .o_done    (done),
    .o_word    (asm_word)
  );

  always_comb begin
    state_d   = state_q;
    bank_a_d  = bank_a_q;
    bank_b_d  = bank_b_q;
    wr_bank_d = wr_bank_q;
    sel_d     = sel_q;
    drop_d    = drop_q;
    ovf_d     = 1'b0;
    // The ready flag doubles as the pending flag; an ack is applied before any commit
    pending_after = rdy_q && !iLINE_ACK;
    rdy_d         = pending_after;
    case (state_q)
      ST_IDLE: begin
        if (accept && iLINE_START) state_d = done ? ST_COMMIT : ST_FILL;
      end
      ST_FILL: begin
        if (done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (!pending_after) begin
          if (wr_bank_q == BANK_A) bank_a_d = asm_word;
          else                     bank_b_d = asm_word;
          sel_d     = (wr_bank_q == BANK_A);
          rdy_d     = 1'b1;
          wr_bank_d = (wr_bank_q == BANK_A) ? BANK_B : BANK_A;
        end else begin
          ovf_d = 1'b1;
          if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      bank_a_q  <= '0;
      bank_b_q  <= '0;
      wr_bank_q <= BANK_A;
      sel_q     <= 1'b0;
      rdy_q     <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      bank_a_q  <= bank_a_d;
      bank_b_q  <= bank_b_d;
      wr_bank_q <= wr_bank_d;
      sel_q     <= sel_d;
      rdy_q     <= rdy_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  assign oMEMOUT_0A = bank_a_q;
  assign oMEMOUT_0B = bank_b_q;
  assign oMEM_SEL   = sel_q;
  assign oLINE_RDY  = rdy_q;
  assign oOVF       = ovf_q;
  assign oDROP_CNT  = drop_q;

endmodule
`default_nettype wire
